// File: rtl/axil_pkg.sv
// Shared response codes and FSM state types for the AXI4-Lite register slave.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wr_state_t;
    typedef enum logic {R_IDLE, R_RESP} rd_state_t;

endpackage

// File: rtl/axil_reg_slave.sv
// AXI4-Lite control/status register file for the DMA engine: RW control regs exported
// flat with per-register commit pulses, RO regs returning live status inputs.
module axil_reg_slave
    import axil_pkg::*;
#(
    parameter int unsigned                 ADDR_W    = 8,
    parameter int unsigned                 DATA_W    = 32,
    parameter int unsigned                 NUM_REGS  = 8,
    parameter logic [NUM_REGS-1:0]         RO_MASK   = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]  RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [ADDR_W-1:0]            awaddr,
    input  logic [2:0]                   awprot,
    input  logic                         awvalid,
    output logic                         awready,
    input  logic [DATA_W-1:0]            wdata,
    input  logic [DATA_W/8-1:0]          wstrb,
    input  logic                         wvalid,
    output logic                         wready,
    output logic [1:0]                   bresp,
    output logic                         bvalid,
    input  logic                         bready,
    input  logic [ADDR_W-1:0]            araddr,
    input  logic [2:0]                   arprot,
    input  logic                         arvalid,
    output logic                         arready,
    output logic [DATA_W-1:0]            rdata,
    output logic [1:0]                   rresp,
    output logic                         rvalid,
    input  logic                         rready,
    output logic [NUM_REGS*DATA_W-1:0]   ctrl_o,
    output logic [NUM_REGS-1:0]          wr_pulse_o,
    input  logic [NUM_REGS*DATA_W-1:0]   status_i
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned IDX_W  = ADDR_W - 2;

    wr_state_t                 w_state_q, w_state_d;
    logic                      aw_held_q, aw_held_d;
    logic                      w_held_q, w_held_d;
    logic [IDX_W-1:0]          aw_idx_q, aw_idx_d;
    logic [DATA_W-1:0]         w_data_q, w_data_d;
    logic [STRB_W-1:0]         w_strb_q, w_strb_d;
    logic                      awready_q, awready_d;
    logic                      wready_q, wready_d;
    logic                      bvalid_q, bvalid_d;
    logic [1:0]                bresp_q, bresp_d;
    logic [NUM_REGS*DATA_W-1:0] ctrl_q, ctrl_d;
    logic [NUM_REGS-1:0]       wr_pulse_q, wr_pulse_d;

    rd_state_t                 r_state_q, r_state_d;
    logic                      rd_pend_q, rd_pend_d;
    logic [IDX_W-1:0]          ar_idx_q, ar_idx_d;
    logic                      arready_q, arready_d;
    logic                      rvalid_q, rvalid_d;
    logic [1:0]                rresp_q, rresp_d;
    logic [DATA_W-1:0]         rdata_q, rdata_d;

    logic                      aw_in_range_c;
    logic                      ar_in_range_c;
    logic                      unused_inputs;

    assign aw_in_range_c = 32'(aw_idx_q) < NUM_REGS;
    assign ar_in_range_c = 32'(ar_idx_q) < NUM_REGS;
    assign unused_inputs = ^{awprot, arprot, awaddr[1:0], araddr[1:0]};

    // Write channel: collect AW and W independently, commit one edge after both are held.
    always_comb begin
        w_state_d  = w_state_q;
        aw_held_d  = aw_held_q;
        w_held_d   = w_held_q;
        aw_idx_d   = aw_idx_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        ctrl_d     = ctrl_q;
        wr_pulse_d = '0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_held_q && w_held_q) begin
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (aw_idx_q == IDX_W'(i) && !RO_MASK[i]) begin
                            wr_pulse_d[i] = 1'b1;
                            for (int unsigned b = 0; b < STRB_W; b++) begin
                                if (w_strb_q[b]) begin
                                    ctrl_d[i*DATA_W + b*8 +: 8] = w_data_q[b*8 +: 8];
                                end
                            end
                        end
                    end
                    bresp_d   = aw_in_range_c ? RESP_OKAY : RESP_SLVERR;
                    bvalid_d  = 1'b1;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    if (awvalid && awready_q) begin
                        aw_held_d = 1'b1;
                        aw_idx_d  = awaddr[ADDR_W-1:2];
                    end
                    if (wvalid && wready_q) begin
                        w_held_d = 1'b1;
                        w_data_d = wdata;
                        w_strb_d = wstrb;
                    end
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
        awready_d = (w_state_d == W_IDLE) && !aw_held_d;
        wready_d  = (w_state_d == W_IDLE) && !w_held_d;
    end

    // Read channel: address taken one edge, data captured the next from the current regs.
    always_comb begin
        r_state_d = r_state_q;
        rd_pend_d = rd_pend_q;
        ar_idx_d  = ar_idx_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid && arready_q) begin
                    ar_idx_d  = araddr[ADDR_W-1:2];
                    rd_pend_d = 1'b1;
                    r_state_d = R_RESP;
                end
            end
            R_RESP: begin
                if (rd_pend_q) begin
                    rd_pend_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rresp_d   = ar_in_range_c ? RESP_OKAY : RESP_SLVERR;
                    rdata_d   = '0;
                    for (int unsigned i = 0; i < NUM_REGS; i++) begin
                        if (ar_idx_q == IDX_W'(i)) begin
                            rdata_d = RO_MASK[i] ? status_i[i*DATA_W +: DATA_W]
                                                 : ctrl_q[i*DATA_W +: DATA_W];
                        end
                    end
                end else if (rready) begin
                    rvalid_d  = 1'b0;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q  <= W_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            ctrl_q     <= RESET_VAL;
            wr_pulse_q <= '0;
            r_state_q  <= R_IDLE;
            rd_pend_q  <= 1'b0;
            ar_idx_q   <= '0;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
        end else begin
            w_state_q  <= w_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_idx_q   <= aw_idx_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            ctrl_q     <= ctrl_d;
            wr_pulse_q <= wr_pulse_d;
            r_state_q  <= r_state_d;
            rd_pend_q  <= rd_pend_d;
            ar_idx_q   <= ar_idx_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
        end
    end

    assign awready    = awready_q;
    assign wready     = wready_q;
    assign bvalid     = bvalid_q;
    assign bresp      = bresp_q;
    assign arready    = arready_q;
    assign rvalid     = rvalid_q;
    assign rresp      = rresp_q;
    assign rdata      = rdata_q;
    assign ctrl_o     = ctrl_q;
    assign wr_pulse_o = wr_pulse_q;

endmodule
